// File: rtl/spi_seq_pkg.sv
// rtl/spi_seq_pkg.sv - shared types and frame layout for the SPI frame sequencer
package spi_seq_pkg;
  localparam int FRAME_W  = 32;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_LSB = 16;
  localparam int DATA_LSB = 0;

  typedef enum logic [2:0] {IDLE, SEND, WAIT_LOW, WAIT_HIGH, GAP, RETRY} seq_state_t;

  typedef struct packed {
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] data;
  } seq_req_t;

  // Upper byte of the frame is always zero on the wire.
  function automatic logic [FRAME_W-1:0] format_frame(seq_req_t r);
    logic [FRAME_W-1:0] f;
    f = '0;
    f[CMD_LSB +: 4]   = r.cmd;
    f[ADDR_LSB +: 4]  = r.addr;
    f[DATA_LSB +: 16] = r.data;
    return f;
  endfunction
endpackage

// File: rtl/spi_req_fifo.sv
// rtl/spi_req_fifo.sv - request buffer between the write handshake and the frame FSM
module spi_req_fifo
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic     sclk,
  input  logic     reset,
  input  logic     push,
  input  logic     pop,
  input  seq_req_t din,
  output seq_req_t dout,
  output logic     full,
  output logic     empty
);
  localparam int AW = $clog2(FIFO_DEPTH);

  seq_req_t    mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;

  // Extra pointer bit tells full from empty when the index bits match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge sclk) begin
    if (push && !full) mem[wr_ptr[AW-1:0]] <= din;
  end
endmodule

// File: rtl/spi_frame_sequencer.sv
// rtl/spi_frame_sequencer.sv - paces buffered write requests into the SPI driver one frame at a time
module spi_frame_sequencer
  import spi_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CS_TIMEOUT = 8,
  parameter int GAP_CYCLES = 2
) (
  input  logic        sclk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [3:0]  req_addr,
  input  logic [15:0] req_data,
  output logic [31:0] pdi,
  output logic        send,
  input  logic        cs,
  output logic        busy,
  output logic [15:0] frame_count,
  output logic        err,
  input  logic        err_clear
);
  localparam logic [2:0] S_IDLE      = IDLE;
  localparam logic [2:0] S_SEND      = SEND;
  localparam logic [2:0] S_WAIT_LOW  = WAIT_LOW;
  localparam logic [2:0] S_WAIT_HIGH = WAIT_HIGH;
  localparam logic [2:0] S_GAP       = GAP;
  localparam logic [2:0] S_RETRY     = RETRY;
  localparam int TW = $clog2(CS_TIMEOUT + GAP_CYCLES + 1);

  logic [2:0]    state;
  logic [TW-1:0] timer;
  logic          retry;
  logic [15:0]   frame_cnt;
  logic          full, empty, pop, timeout, drop;
  seq_req_t      req_in, head;

  assign req_in      = {req_cmd, req_addr, req_data};
  assign req_ready   = !full;
  assign pop         = (state == S_IDLE) && !empty;
  assign busy        = (state != S_IDLE) || !empty;
  assign frame_count = frame_cnt;
  assign timeout     = (state == S_WAIT_LOW) && cs && (timer == TW'(CS_TIMEOUT - 1));
  assign drop        = timeout && retry;

  spi_req_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .sclk  (sclk),
    .reset (reset),
    .push  (req_valid && req_ready),
    .pop   (pop),
    .din   (req_in),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      pdi       <= '0;
      send      <= 1'b0;
      timer     <= '0;
      retry     <= 1'b0;
      frame_cnt <= '0;
    end else begin
      case (state)
        S_IDLE: if (!empty) begin
          pdi   <= format_frame(head);
          retry <= 1'b0;
          state <= S_SEND;
        end
        S_SEND: begin
          send  <= 1'b1;
          timer <= '0;
          state <= S_WAIT_LOW;
        end
        S_WAIT_LOW: begin
          if (!cs) begin
            state <= S_WAIT_HIGH;
          end else if (timeout) begin
            send  <= 1'b0;
            timer <= '0;
            retry <= 1'b1;
            state <= retry ? S_GAP : S_RETRY;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        // SEND itself adds one low cycle, so RETRY exits one count early.
        S_RETRY: begin
          if (timer + TW'(2) >= TW'(GAP_CYCLES)) state <= S_SEND;
          else timer <= timer + 1'b1;
        end
        S_WAIT_HIGH: if (cs) begin
          send      <= 1'b0;
          frame_cnt <= frame_cnt + 1'b1;
          timer     <= '0;
          state     <= S_GAP;
        end
        S_GAP: begin
          if (timer == TW'(GAP_CYCLES - 1)) state <= S_IDLE;
          else timer <= timer + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge sclk or posedge reset) begin
    if (reset) err <= 1'b0;
    else if (drop) err <= 1'b1;
    else if (err_clear) err <= 1'b0;
  end
endmodule

// File: tb/tb_spi_frame_sequencer.sv
// tb/tb_spi_frame_sequencer.sv - scoreboard bench with an SPI driver model for spi_frame_sequencer
module tb_spi_frame_sequencer;
  localparam int FIFO_DEPTH = 4;
  localparam int CS_TIMEOUT = 8;
  localparam int GAP_CYCLES = 2;

  logic        sclk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        err_clear = 1'b0;
  logic [3:0]  req_cmd = '0;
  logic [3:0]  req_addr = '0;
  logic [15:0] req_data = '0;
  logic        req_ready, send, busy, err;
  logic [31:0] pdi;
  logic [15:0] frame_count;
  logic        cs = 1'b1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];
  int          high_hist[$];
  int          low_hist[$];
  logic [15:0] exp_count = '0;
  int          ign_total = 0;
  int          eh;

  spi_frame_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .CS_TIMEOUT(CS_TIMEOUT), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .sclk(sclk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_addr(req_addr), .req_data(req_data),
    .pdi(pdi), .send(send), .cs(cs), .busy(busy), .frame_count(frame_count),
    .err(err), .err_clear(err_clear)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] frame_of(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d);
    return 32'(c) * 32'h0010_0000 + 32'(a) * 32'h0001_0000 + 32'(d);
  endfunction

  // Driver model: edge-detects send, holds cs low 32 cycles; can ignore a number of send edges.
  logic        send_d = 1'b0;
  logic        drv_busy = 1'b0;
  logic        drv_untracked = 1'b0;
  int          drv_cnt = 0;
  int          ign_done = 0;
  logic [31:0] drv_frame = '0;

  always @(posedge sclk) begin
    send_d <= send;
    if (reset && drv_busy) drv_untracked <= 1'b1;
    if (drv_busy) begin
      if (drv_cnt == 31) begin
        cs       <= 1'b1;
        drv_busy <= 1'b0;
      end else begin
        drv_cnt <= drv_cnt + 1;
      end
    end else if (send && !send_d) begin
      if (ign_done < ign_total) begin
        ign_done <= ign_done + 1;
      end else begin
        cs            <= 1'b0;
        drv_busy      <= 1'b1;
        drv_cnt       <= 0;
        drv_frame     <= pdi;
        drv_untracked <= 1'b0;
      end
    end
  end

  // Monitor: scoreboard pop on each tracked frame completion, plus send-edge timing.
  initial begin
    logic        send_p = 1'b0;
    logic        cs_p = 1'b1;
    logic [31:0] pdi_p = '0;
    int          hi_run = 0;
    int          lo_run = 0;
    forever begin
      @(negedge sclk);
      if (send && !send_p) begin
        low_hist.push_back(lo_run);
        check("gap_before_send", 32'(lo_run >= GAP_CYCLES), 32'd1);
        check("pdi_setup", pdi, pdi_p);
        lo_run = 0;
      end
      if (!send && send_p) begin
        high_hist.push_back(hi_run);
        hi_run = 0;
      end
      if (send) hi_run++;
      else lo_run++;
      if (cs && !cs_p && !drv_untracked) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_frame: got 0x%0h required none", drv_frame);
        end else begin
          check("frame_data", drv_frame, exp_q.pop_front());
          check("pdi_hold", pdi, drv_frame);
        end
      end
      send_p = send;
      cs_p   = cs;
      pdi_p  = pdi;
    end
  end

  task automatic push_req(input logic [3:0] c, input logic [3:0] a, input logic [15:0] d, input bit expect_out);
    int n = 0;
    req_valid = 1'b1;
    req_cmd   = c;
    req_addr  = a;
    req_data  = d;
    while (!req_ready && n < 3000) begin
      @(negedge sclk);
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: req_ready=%0b required 1", req_ready);
    end else begin
      if (expect_out) exp_q.push_back(frame_of(c, a, d));
      @(negedge sclk);
    end
    req_valid = 1'b0;
  endtask

  task automatic push_rand(input bit expect_out);
    push_req(4'($urandom), 4'($urandom), 16'($urandom), expect_out);
  endtask

  task automatic wait_idle(output int err_hi);
    int n = 0;
    err_hi = 0;
    while ((busy || drv_busy || !cs) && n < 5000) begin
      if (err) err_hi++;
      @(negedge sclk);
      n++;
    end
    if (n >= 5000) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: busy=%0b required 0", busy);
    end
  endtask

  task automatic wait_cs(input logic v);
    int n = 0;
    while (cs !== v && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    if (cs !== v) begin
      checks++;
      errors++;
      $display("FAIL wait_cs: cs=%0b required %0b", cs, v);
    end
  endtask

  task automatic wait_send_high();
    int n = 0;
    while (!send && n < 2000) begin
      @(negedge sclk);
      n++;
    end
    if (!send) begin
      checks++;
      errors++;
      $display("FAIL wait_send: send=%0b required 1", send);
    end
  endtask

  task automatic idle_checks(input string tag);
    check({tag, "_frame_count"}, 32'(frame_count), 32'(exp_count));
    check({tag, "_queue_drained"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge sclk);
    reset = 1'b0;
    @(negedge sclk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_send", 32'(send), 32'd0);
    check("rst_pdi", pdi, 32'd0);
    check("rst_frame_count", 32'(frame_count), 32'd0);
    check("rst_err", 32'(err), 32'd0);

    // Single known request.
    push_req(4'd3, 4'd1, 16'hBEEF, 1'b1);
    check("known_frame_model", frame_of(4'd3, 4'd1, 16'hBEEF), 32'h0031_BEEF);
    wait_idle(eh);
    exp_count = exp_count + 16'd1;
    idle_checks("single");

    // One frame in flight, then fill the FIFO, then one more that must wait.
    push_rand(1'b1);
    wait_send_high();
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      push_rand(1'b1);
      check("ready_after_push", 32'(req_ready), 32'(i < FIFO_DEPTH - 1));
    end
    push_rand(1'b1);
    wait_idle(eh);
    exp_count = exp_count + 16'(FIFO_DEPTH + 2);
    idle_checks("burst");

    // Driver ignores the first send edge: one timeout and a retry.
    high_hist.delete();
    low_hist.delete();
    ign_total += 1;
    push_rand(1'b1);
    wait_idle(eh);
    exp_count = exp_count + 16'd1;
    check("retry_rises", 32'(low_hist.size()), 32'd2);
    if (low_hist.size() >= 2 && high_hist.size() >= 1) begin
      check("retry_send_high_len", 32'(high_hist[0]), 32'(CS_TIMEOUT));
      check("retry_send_low_len", 32'(low_hist[1]), 32'(GAP_CYCLES));
    end
    check("retry_err", 32'(err), 32'd0);
    idle_checks("retry");

    // Driver never answers one frame: dropped, err set, next frame still goes.
    ign_total += 2;
    push_rand(1'b0);
    push_rand(1'b1);
    wait_idle(eh);
    exp_count = exp_count + 16'd1;
    check("drop_err", 32'(err), 32'd1);
    idle_checks("drop");

    // Counter wrap, err stays set.
    @(negedge sclk);
    force dut.frame_cnt = 16'hFFFE;
    @(negedge sclk);
    release dut.frame_cnt;
    exp_count = 16'hFFFE;
    check("preset_count", 32'(frame_count), 32'h0000_FFFE);
    push_rand(1'b1);
    push_rand(1'b1);
    wait_idle(eh);
    exp_count = exp_count + 16'd2;
    idle_checks("wrap");
    check("wrap_err_kept", 32'(err), 32'd1);

    // err_clear pulse.
    err_clear = 1'b1;
    @(negedge sclk);
    err_clear = 1'b0;
    check("err_cleared", 32'(err), 32'd0);

    // Set beats a held clear: err visible for exactly one cycle.
    err_clear = 1'b1;
    ign_total += 2;
    push_rand(1'b0);
    wait_idle(eh);
    err_clear = 1'b0;
    check("err_set_wins_cycles", 32'(eh), 32'd1);
    check("err_after_held_clear", 32'(err), 32'd0);
    idle_checks("set_vs_clear");

    // Reset while cs is low with requests still queued.
    push_rand(1'b1);
    push_rand(1'b1);
    push_rand(1'b1);
    wait_cs(1'b0);
    repeat (5) @(negedge sclk);
    @(posedge sclk);
    #2 reset = 1'b1;
    #1;
    check("midrst_send", 32'(send), 32'd0);
    check("midrst_pdi", pdi, 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_frame_count", 32'(frame_count), 32'd0);
    exp_q.delete();
    exp_count = '0;
    repeat (2) @(negedge sclk);
    reset = 1'b0;
    wait_cs(1'b1);
    @(negedge sclk);
    push_rand(1'b1);
    wait_idle(eh);
    exp_count = exp_count + 16'd1;
    idle_checks("post_reset");

    // Randomized traffic with random spacing.
    for (int i = 0; i < 20; i++) begin
      repeat ($urandom_range(0, 40)) @(negedge sclk);
      push_rand(1'b1);
      exp_count = exp_count + 16'd1;
    end
    wait_idle(eh);
    idle_checks("random");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
